// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths, FSM
// encoding and requester index type.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int REQ_IDX_W  = 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  localparam req_idx_t REQ0 = req_idx_t'(0);
  localparam req_idx_t REQ1 = req_idx_t'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RD_CAP = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin pick: on a tie the requester that did not win last
// time is chosen; a lone request always wins.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last,
  output req_idx_t winner,
  output logic     valid
);

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    valid  = req0 | req1;
    winner = REQ0;
    if (req0 && req1) begin
      winner = (last == REQ0) ? REQ1 : REQ0;
    end else if (req1) begin
      winner = REQ1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of a 64x8 single-port RAM:
// one command in flight, registered RAM pins, gnt/done pulses per requester.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out
);

  state_t   state, state_next;
  req_idx_t last, owner, pick;
  logic     pick_valid;
  logic     accept, finish_wr, finish_rd, finish;

  ram_arb_rr2 u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  // In ACCESS, ram_we still carries the accepted command's direction.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish_wr  = 1'b0;
    finish_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_we) begin
          finish_wr  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RD_CAP;
        end
      end
      RD_CAP: begin
        finish_rd  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign finish = finish_wr | finish_rd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= REQ1;
      owner    <= REQ0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      state <= state_next;
      gnt0  <= accept && (pick == REQ0);
      gnt1  <= accept && (pick == REQ1);
      done0 <= finish && (owner == REQ0);
      done1 <= finish && (owner == REQ1);

      if (accept) begin
        owner    <= pick;
        last     <= pick;
        ram_we   <= (pick == REQ1) ? we1    : we0;
        ram_addr <= (pick == REQ1) ? addr1  : addr0;
        ram_data <= (pick == REQ1) ? wdata1 : wdata0;
      end else begin
        ram_we <= 1'b0;
      end

      if (finish_rd) begin
        if (owner == REQ1) rdata1 <= ram_out;
        else               rdata0 <= ram_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM stand-in and a
// transaction-level model of arbitration, occupancy and memory contents.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int DEPTH = 2 ** AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, ram_data, ram_out;
  logic          gnt0, gnt1, done0, done1, ram_we;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_out(ram_out)
  );

  // Stand-in for the por RAM: synchronous write, registered read.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_out <= ram_mem[ram_addr];
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata [2];
  logic          m_last;
  int            busy, done_left;
  logic          done_who;
  cmd_t          done_cmd;

  // Requester-side intent
  logic pend [2];
  cmd_t cmd  [2];
  bit   hold [2];
  int   order [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we   = 1'($urandom_range(0, 1));
    c.addr = AW'($urandom_range(16, DEPTH - 1));
    c.data = DW'($urandom);
    return c;
  endfunction

  task automatic drive();
    req0 = pend[0]; we0 = cmd[0].we; addr0 = cmd[0].addr; wdata0 = cmd[0].data;
    req1 = pend[1]; we1 = cmd[1].we; addr1 = cmd[1].addr; wdata1 = cmd[1].data;
  endtask

  // One clock: predict the edge from the request rules, then compare outputs
  // on the following falling edge and present the next stimulus.
  task automatic step();
    logic r [2];
    cmd_t c [2];
    logic rs, w, got;
    logic [1:0] e_gnt, e_done;
    logic e_we;
    cmd_t e_cmd;
    r[0] = req0; r[1] = req1;
    c[0] = {we0, addr0, wdata0};
    c[1] = {we1, addr1, wdata1};
    rs = rst;
    @(posedge clk);
    e_gnt = '0; e_done = '0; e_we = 1'b0; got = 1'b0; e_cmd = '0;
    if (rs) begin
      busy = 0; done_left = 0; m_last = 1'b1;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      if (done_left > 0) begin
        done_left--;
        if (done_left == 0) begin
          e_done[done_who] = 1'b1;
          if (done_cmd.we) m_mem[done_cmd.addr] = done_cmd.data;
          else             m_rdata[done_who] = m_mem[done_cmd.addr];
        end
      end
      if (busy > 0) begin
        busy--;
      end else if (r[0] || r[1]) begin
        w = (r[0] && r[1]) ? ~m_last : r[1];
        m_last = w;
        e_gnt[w] = 1'b1;
        e_cmd = c[w];
        e_we = c[w].we;
        got = 1'b1;
        done_who = w;
        done_cmd = c[w];
        busy = c[w].we ? 1 : 2;
        done_left = busy;
        pend[w] = hold[w];
        if (hold[w]) cmd[w] = rand_cmd();
      end
    end
    @(negedge clk);
    check("gnt0", gnt0, e_gnt[0]);
    check("gnt1", gnt1, e_gnt[1]);
    check("gnt_excl", gnt0 & gnt1, 0);
    check("done0", done0, e_done[0]);
    check("done1", done1, e_done[1]);
    check("ram_we", ram_we, e_we);
    check("rdata0", rdata0, m_rdata[0]);
    check("rdata1", rdata1, m_rdata[1]);
    if (got) begin
      check("ram_addr", ram_addr, e_cmd.addr);
      check("ram_data", ram_data, e_cmd.data);
    end
    if (rs) begin
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
    end
    drive();
  endtask

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while ((pend[0] || pend[1] || busy > 0 || done_left > 0) && n < max_cycles) begin
      step();
      n++;
    end
  endtask

  task automatic issue(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[who] = 1'b1;
    cmd[who]  = {we, a, d};
    drive();
    run_idle(20);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    ram_out = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_last = 1'b1; busy = 0; done_left = 0; done_who = 1'b0; done_cmd = '0;
    hold[0] = 0; hold[1] = 0;
    pend[1] = 1'b0; cmd[1] = '0;
    // Request already pending while reset is high must wait for reset release.
    pend[0] = 1'b1; cmd[0] = {1'b1, 6'd1, 8'hb4};
    rst = 1'b1;
    drive();
    step();
    step();
    rst = 1'b0;
    run_idle(20);

    issue(0, 1'b1, 6'd2, 8'h74);
    issue(0, 1'b1, 6'd3, 8'hc3);

    issue(1, 1'b0, 6'd2, 8'h00);
    check("rd_a2", rdata1, 8'h74);
    issue(1, 1'b0, 6'd1, 8'h00);
    check("rd_a1", rdata1, 8'hb4);
    check("rdata0_hold", rdata0, 8'h00);

    // Simultaneous writes: requester 0 must win the tie.
    pend[0] = 1'b1; cmd[0] = {1'b1, 6'd50, 8'h5c};
    pend[1] = 1'b1; cmd[1] = {1'b1, 6'd51, 8'hab};
    drive();
    order.delete();
    for (int n = 0; n < 20 && (pend[0] || pend[1] || busy > 0 || done_left > 0); n++) begin
      step();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    check("tie_cnt", order.size(), 2);
    if (order.size() == 2) begin
      check("tie_first", order[0], 0);
      check("tie_second", order[1], 1);
    end
    issue(0, 1'b0, 6'd50, 8'h00);
    check("rd_a50", rdata0, 8'h5c);
    issue(1, 1'b0, 6'd51, 8'h00);
    check("rd_a51", rdata1, 8'hab);

    // Both holding requests: grants must alternate starting with 0.
    hold[0] = 1; hold[1] = 1;
    pend[0] = 1'b1; cmd[0] = rand_cmd();
    pend[1] = 1'b1; cmd[1] = rand_cmd();
    drive();
    order.delete();
    for (int n = 0; n < 60 && order.size() < 6; n++) begin
      step();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    check("hold_cnt", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) check("hold_order", order[i], i % 2);
    hold[0] = 0; hold[1] = 0;
    run_idle(30);

    // Reset while capturing read data of address 3.
    pend[0] = 1'b1; cmd[0] = {1'b0, 6'd3, 8'h00};
    drive();
    step();
    check("rd3_gnt", gnt0, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check("rd3_no_done", done0, 0);
    check("rd3_rdata0", rdata0, 0);
    pend[0] = 1'b1; cmd[0] = {1'b1, 6'd20, 8'h11};
    pend[1] = 1'b1; cmd[1] = {1'b1, 6'd21, 8'h22};
    drive();
    order.delete();
    for (int n = 0; n < 20 && (pend[0] || pend[1] || busy > 0 || done_left > 0); n++) begin
      step();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    check("post_rst_cnt", order.size(), 2);
    if (order.size() > 0) check("post_rst_first", order[0], 0);

    // Command changed after grant must be ignored.
    pend[0] = 1'b1; cmd[0] = {1'b1, 6'd1, 8'hb4};
    drive();
    step();
    check("chg_gnt", gnt0, 1);
    cmd[0].addr = 6'd2;
    drive();
    run_idle(20);
    issue(0, 1'b0, 6'd1, 8'h00);
    check("chg_a1", rdata0, 8'hb4);
    issue(0, 1'b0, 6'd2, 8'h00);
    check("chg_a2", rdata0, 8'h74);

    // Random traffic from both requesters.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          cmd[i]  = rand_cmd();
        end
      end
      drive();
      step();
    end
    run_idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer in front of the 64x8 single-port RAM (por). Two requesters each issue single-word read or write commands. The block grants one requester at a time and drives the RAM's data/addr/we pins from registers. It captures the RAM's out for reads and returns it to the winning requester with a completion pulse.

## Interface
- ADDR_W, 6, address width (64 words)
- DATA_W, 8, data width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held with command until gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: command captured
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DATA_W  read data, valid while matching done is high after a read
- ram_data  out  DATA_W  to RAM data
- ram_addr  out  ADDR_W  to RAM addr
- ram_we  out  1  to RAM we
- ram_out  in  DATA_W  from RAM out

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - ACCESS: RAM sampling the command.
  - RD_CAP: capturing read data.
- IDLE:
  - If any req is high at the edge, pick a winner.
  - Latch its we/addr/wdata into ram_we/ram_addr/ram_data.
  - Pulse that requester's gnt and move to ACCESS.
  - With no request, stay in IDLE with ram_we = 0.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The last-winner pointer resets to 1, so requester 0 wins the first tie.
- ACCESS: ram_we returns to 0 (ram_addr held).
  - Write: pulse done of the owner and return to IDLE.
  - Read: move to RD_CAP.
- RD_CAP:
  - Register ram_out into the owner's rdata.
  - Pulse the owner's done and return to IDLE.
- Requester rules:
  - The command is sampled only at the grant edge; changes after gnt are ignored.
  - A req still high in the cycle after gnt counts as a new request.
- gnt and done are never high for both requesters in the same cycle. At most one command is in flight.
- rdata of the non-owner holds its previous value.

## Timing
- Edge E0: the command is accepted (state IDLE, req high). gnt is high in the cycle after E0, and ram_* outputs are valid from E0.
- Edge E1: the RAM commits the write or registers the read address. For a write, done is high in the cycle after E1.
- Edge E2: for a read, ram_out is captured. done and rdata are valid in the cycle after E2.
- Occupancy: a write takes 2 cycles and a read takes 3. The earliest next grant is at E2 after a write and at E3 after a read.
- A request held continuously by one requester is serviced back-to-back at that rate.
- Reset values: state IDLE, all gnt/done 0, all rdata 0, ram_we 0, ram_addr 0, ram_data 0, pointer = 1.
- Reset mid-operation:
  - An in-flight read is discarded with no done.
  - A write that has passed E0 but not E1 may not commit. ram_we is forced to 0 the cycle after rst.
- rst high with req high: no grant until the first edge with rst low.

## Structure
- Shared package ram_arb_pkg: ADDR_W and DATA_W defaults, the state encoding (IDLE, ACCESS, RD_CAP), and the requester index width.
- One sub-module, ram_arb_rr2: combinational two-way round-robin pick from req0, req1 and the last pointer. Outputs are a winner index and a valid flag.
- The FSM, command registers and rdata capture live in ram_arbiter. It instantiates no RAM; the bench instantiates por alongside it.

## Test plan
- Single writes from requester 0: b4@1, 74@2, c3@3. Each gives gnt0 at E0+1 and done0 at E1+1; ram_we is high exactly one cycle per write.
- Reads from requester 1 of addr 2 then addr 1: done1 at E2+1 with rdata1 = 74, then with rdata1 = b4. rdata0 is unchanged.
- Both requesting on the same edge:
  - Requester 0 writes 5c@50 and requester 1 writes ab@51.
  - Required grant order is gnt0 then gnt1, and both writes commit.
  - A subsequent read of 50 returns 5c and a read of 51 returns ab.
- Both holding req continuously for 6 grants: grants alternate 0,1,0,1,0,1 with no gnt overlap.
- rst asserted in RD_CAP of a read of addr 3: no done follows, and all outputs return to reset values. The next request grants requester 0 first.
- Command changed after gnt (addr0 1 -> 2 the cycle after gnt0 on a write of b4): only address 1 is written, and address 2 still reads 74.
